uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver: the serial-to-parallel counterpart of the team's PISO-based transmitter.
- Frame format: 1 start bit (0), DW data bits LSB first, optional even parity bit, 1 stop bit (1).
- Oversamples the asynchronous rx line with the system clock, samples each bit at its centre, and assembles it in a SIPO shift register.
- Presents the received word with a one-cycle done strobe and error flags. Sits between the board RX pin and the user logic or FIFO.

Parameters:
- DW, 8, data bits per frame.
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200). Must be >= 4.
- PARITY_EN, 0, 1 = expect an even-parity bit after the data bits.

Ports:
- clk  input  1  system clock, rising edge.
- nrst  input  1  reset. One clock; reset is synchronous and active-high.
- rx  input  1  asynchronous serial line, idle high.
- data  output  DW  last received word, held until the next frame completes.
- rx_done  output  1  one-cycle pulse when a frame completes, including frames with errors.
- frame_err  output  1  stop bit sampled 0 in the last frame; valid from rx_done until the next rx_done.
- parity_err  output  1  parity mismatch in the last frame; always 0 when PARITY_EN=0.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (nrst=1 at posedge clk):
  - state=IDLE; synchroniser flops=1; bit and clock counters=0; shift register=0.
  - data=0, rx_done=0, frame_err=0, parity_err=0, busy=0.
  - Reset mid-frame aborts the frame with no rx_done pulse.
- Synchroniser: 2-FF chain on rx, giving rx_s. A third flop rx_d holds the previous rx_s. All decisions use rx_s, so there is a 2-cycle input latency.
- IDLE: a falling edge (rx_d=1, rx_s=0) moves to START with clk_cnt=0. A line held low (break) never retriggers.
- START: clk_cnt counts up. At clk_cnt = CLKS_PER_BIT/2 - 1 (integer division), rx_s is sampled:
  - 0: go to DATA with clk_cnt=0, bit_cnt=0.
  - 1: glitch; return to IDLE with no strobe and no flags changed.
- DATA: at each clk_cnt = CLKS_PER_BIT-1, rx_s is shifted in: sreg <= {rx_s, sreg[DW-1:1]}, so the first bit received ends up at bit 0. clk_cnt resets and bit_cnt increments. After bit DW-1, go to PARITY if PARITY_EN, else STOP.
- PARITY: sample at clk_cnt = CLKS_PER_BIT-1. par_bad = rx_s XOR (XOR-reduce of sreg). Then go to STOP.
- STOP: sample at clk_cnt = CLKS_PER_BIT-1. On that edge:
  - data <= sreg.
  - frame_err <= ~rx_s.
  - parity_err <= par_bad (0 when parity is disabled).
  - rx_done <= 1 for exactly one cycle.
  - state <= IDLE.
  - data is updated even when an error is flagged.
- Timing: let t0 be the edge where IDLE sees the falling edge.
  - Start sample at t0 + CLKS_PER_BIT/2.
  - Bit i sample at t0 + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT.
  - Stop sample at t0 + CLKS_PER_BIT/2 + (DW+1+PARITY_EN)·CLKS_PER_BIT.
  - rx_done is visible in the cycle after the stop sample.
- Back-to-back frames: a start edge arriving immediately after the stop sample is accepted. The first IDLE cycle evaluates the edge.
- Counter widths: clk_cnt is $clog2(CLKS_PER_BIT) bits; bit_cnt is $clog2(DW+1) bits; no wrap inside a frame.

Decomposition:
- Package uart_pkg holds:
  - state encoding (IDLE, START, DATA, PARITY, STOP; 3-bit localparams);
  - default DW and CLKS_PER_BIT, shared with the transmitter.
- Sub-module sipo (Serial Input Parallel Output), the mirror of the transmitter's PISO:
  - ports clk, nrst, enable, din, Q[DW-1:0];
  - right-shift, MSB insert, synchronous active-high reset.
- The FSM and counters live in uart_rx.

Test Plan (bench uses CLKS_PER_BIT=16, DW=8):
- Send 0xA5 with a valid stop bit, PARITY_EN=0 -> one rx_done pulse, data=8'hA5, frame_err=0, busy low after the pulse, pulse at t0+8+9·16 (+1).
- Low glitch of 5 clocks on idle rx -> START aborts at the half-bit sample; no rx_done; busy returns to 0 by cycle 10; data unchanged.
- Send 0x3C with stop bit forced 0, then hold rx low 40 clocks, then high -> rx_done once, data=8'h3C, frame_err=1, no second frame while low.
- PARITY_EN=1: send 0x07 with parity bit 1 (correct), then 0x07 with parity bit 0 -> first frame parity_err=0, second parity_err=1, data=8'h07 both times.
- Back-to-back 0x55 then 0xFF with no idle gap -> two rx_done pulses 160 clocks apart, data 8'h55 then 8'hFF, no errors.
- Assert nrst for 1 cycle mid-DATA on 0x81 -> all outputs 0 next cycle, no rx_done; next clean frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry
// (the defaults are also used by the transmitter).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int unsigned DEFAULT_DW           = 8;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_rx_sipo.sv
// Serial-in parallel-out shift register: right shift with MSB insert, so the
// first bit shifted in ends up at bit 0 after DW shifts.
module sipo
    import uart_pkg::*;
#(
    parameter int unsigned DW = DEFAULT_DW
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          enable,
    input  logic          din,
    output logic [DW-1:0] Q
);

    logic [DW-1:0] q_q;
    logic [DW-1:0] q_d;

    // Next shift-register contents: insert din at the MSB when enabled.
    always_comb begin
        q_d = q_q;
        if (enable) begin
            q_d = {din, q_q[DW-1:1]};
        end
    end

    // Shift-register state with synchronous active-high clear.
    always_ff @(posedge clk) begin
        if (nrst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx, detects the start edge, samples every bit at
// its centre and reports the assembled word with a done strobe and error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DW           = DEFAULT_DW,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          rx,
    output logic [DW-1:0] data,
    output logic          rx_done,
    output logic          frame_err,
    output logic          parity_err,
    output logic          busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DW + 1);

    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DW - 1);

    rx_state_e     state_q, state_d;
    logic          rx_meta_q, rx_s_q, rx_d_q;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          par_bad_q, par_bad_d;
    logic [DW-1:0] data_q, data_d;
    logic          rx_done_q, rx_done_d;
    logic          frame_err_q, frame_err_d;
    logic          parity_err_q, parity_err_d;
    logic          shift_en;
    logic [DW-1:0] sreg;

    sipo #(.DW(DW)) u_sipo (
        .clk    (clk),
        .nrst   (nrst),
        .enable (shift_en),
        .din    (rx_s_q),
        .Q      (sreg)
    );

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (nrst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_d_q    <= rx_s_q;
        end
    end

    // Frame sequencing: next state, counters, bit sampling and result capture.
    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        par_bad_d    = par_bad_q;
        data_d       = data_q;
        rx_done_d    = 1'b0;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        shift_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                // Edge-triggered so a line held low (break) cannot retrigger.
                if (rx_d_q && !rx_s_q) begin
                    state_d   = START;
                    par_bad_d = 1'b0;
                end
            end
            START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s_q ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_en  = 1'b1;
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                    if (bit_cnt_q == DATA_LAST) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            PARITY: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    par_bad_d = rx_s_q ^ (^sreg);
                    state_d   = STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d    = '0;
                    data_d       = sreg;
                    frame_err_d  = ~rx_s_q;
                    parity_err_d = PARITY_EN & par_bad_q;
                    rx_done_d    = 1'b1;
                    state_d      = IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q      <= IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            par_bad_q    <= 1'b0;
            data_q       <= '0;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            par_bad_q    <= par_bad_d;
            data_q       <= data_d;
            rx_done_q    <= rx_done_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign data       = data_q;
    assign rx_done    = rx_done_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign busy       = (state_q != IDLE);

endmodule
